multi_blink_generator: RTL and testbench

//  Parametrised multi-channel blink/pulse generator for LED and indicator drive.

---
 rtl/multi_blink_generator.sv | 136 +++++++++++++
 tb/tb_multi_blink_generator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_blink_generator.sv
// Multi-channel blink/pulse generator: each channel runs an independent ON/OFF
// cycle with lengths and burst count latched at start.
module multi_blink_generator #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned BURST_W     = 4,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    input  logic [CNT_W-1:0]    on_len,
    input  logic [CNT_W-1:0]    off_len,
    input  logic [BURST_W-1:0]  burst,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam logic ACT_LVL   = ACTIVE_HIGH;
    localparam logic INACT_LVL = !ACTIVE_HIGH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    // Zero lengths run as one cycle so a phase always has an end.
    logic [CNT_W-1:0] on_eff_c;
    logic [CNT_W-1:0] off_eff_c;

    assign on_eff_c  = (on_len  == '0) ? CNT_W'(1) : on_len;
    assign off_eff_c = (off_len == '0) ? CNT_W'(1) : off_len;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        state_t             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   on_q, on_d;
        logic [CNT_W-1:0]   off_q, off_d;
        logic [BURST_W-1:0] rem_q, rem_d;
        logic               out_q, out_d;
        logic               busy_q, busy_d;
        logic               done_q, done_d;

        // Next-state and registered-output decode; rem_q==0 means continuous.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            on_d    = on_q;
            off_d   = off_q;
            rem_d   = rem_q;
            done_d  = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start[i]) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        on_d    = on_eff_c;
                        off_d   = off_eff_c;
                        rem_d   = burst;
                    end
                end
                S_ON: begin
                    if (cnt_q == on_q - CNT_W'(1)) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (cnt_q == off_q - CNT_W'(1)) begin
                        cnt_d = '0;
                        if (rem_q == '0) begin
                            state_d = S_ON;
                        end else if (rem_q == BURST_W'(1)) begin
                            state_d = S_IDLE;
                            rem_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ON;
                            rem_d   = rem_q - BURST_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Abort wins over everything, including a same-cycle start.
            if (stop[i]) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rem_d   = '0;
                done_d  = 1'b0;
            end

            out_d  = (state_d == S_ON) ? ACT_LVL : INACT_LVL;
            busy_d = (state_d != S_IDLE);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                on_q    <= '0;
                off_q   <= '0;
                rem_q   <= '0;
                out_q   <= INACT_LVL;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                on_q    <= on_d;
                off_q   <= off_d;
                rem_q   <= rem_d;
                out_q   <= out_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
            end
        end

        assign out[i]  = out_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_multi_blink_generator.sv
// Scoreboard bench for multi_blink_generator: stimulus queues per-cycle expected
// levels; a monitor compares both an active-high and an active-low build.
module tb_multi_blink_generator;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned BW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] start, stop;
    logic [CW-1:0] on_len, off_len;
    logic [BW-1:0] burst;
    logic [CH-1:0] out_h, busy_h, done_h;
    logic [CH-1:0] out_l, busy_l, done_l;

    multi_blink_generator #(.CHANNELS(CH), .CNT_W(CW), .BURST_W(BW), .ACTIVE_HIGH(1'b1)) u_dut_h (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .on_len(on_len), .off_len(off_len), .burst(burst),
        .out(out_h), .busy(busy_h), .done(done_h)
    );

    multi_blink_generator #(.CHANNELS(CH), .CNT_W(CW), .BURST_W(BW), .ACTIVE_HIGH(1'b0)) u_dut_l (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .on_len(on_len), .off_len(off_len), .burst(burst),
        .out(out_l), .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // cyc == -1 marks an entry to be checked immediately on async_ev.
    typedef struct {
        int cyc;
        int ch;
        bit act;
        bit bsy;
        bit dn;
        int scen;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   scen   = 0;
    event async_ev;

    always @(negedge clk or async_ev) begin
        exp_t       e;
        logic [2:0] got, req;
        for (int i = q.size() - 1; i >= 0; i--) begin
            e = q[i];
            if (e.cyc == -1 || e.cyc == cyc) begin
                got = {out_h[e.ch], busy_h[e.ch], done_h[e.ch]};
                req = {e.act, e.bsy, e.dn};
                n_chk++;
                if (got !== req) begin
                    n_fail++;
                    $display("FAIL s%0d_hi ch%0d cyc%0d {out,busy,done} got %b want %b", e.scen, e.ch, e.cyc, got, req);
                end
                got = {out_l[e.ch], busy_l[e.ch], done_l[e.ch]};
                req = {~e.act, e.bsy, e.dn};
                n_chk++;
                if (got !== req) begin
                    n_fail++;
                    $display("FAIL s%0d_lo ch%0d cyc%0d {out,busy,done} got %b want %b", e.scen, e.ch, e.cyc, got, req);
                end
                q.delete(i);
            end else if (e.cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL s%0d_missed ch%0d cyc%0d got unchecked want checked", e.scen, e.ch, e.cyc);
                q.delete(i);
            end
        end
    end

    task automatic push(input int c, input int ch, input bit act, input bit bsy, input bit dn);
        exp_t e;
        e.cyc = c; e.ch = ch; e.act = act; e.bsy = bsy; e.dn = dn; e.scen = scen;
        q.push_back(e);
    endtask

    // Burst run started at edge n+1: ON/OFF per burst, then done, then optional idle.
    task automatic push_run(input int ch, input int n, input int on, input int off,
                            input int bursts, input bit tail);
        int c = n + 1;
        int on_e  = (on  == 0) ? 1 : on;
        int off_e = (off == 0) ? 1 : off;
        for (int b = 0; b < bursts; b++) begin
            for (int k = 0; k < on_e;  k++) begin push(c, ch, 1'b1, 1'b1, 1'b0); c++; end
            for (int k = 0; k < off_e; k++) begin push(c, ch, 1'b0, 1'b1, 1'b0); c++; end
        end
        push(c, ch, 1'b0, 1'b0, 1'b1);
        if (tail) push(c + 1, ch, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_cont(input int ch, input int n, input int on, input int off, input int cycles);
        for (int k = 0; k < cycles; k++)
            push(n + 1 + k, ch, ((k % (on + off)) < on), 1'b1, 1'b0);
    endtask

    task automatic push_idle(input int ch, input int from_c, input int cycles);
        for (int k = 0; k < cycles; k++) push(from_c + k, ch, 1'b0, 1'b0, 1'b0);
    endtask

    // Drive one cycle of strobes at the current negedge; the next posedge samples them.
    task automatic poke(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                        input int on, input int off, input int b);
        on_len  = CW'(on);
        off_len = CW'(off);
        burst   = BW'(b);
        start   = st;
        stop    = sp;
        @(negedge clk);
        start = '0;
        stop  = '0;
    endtask

    task automatic launch(input int ch, input int on, input int off, input int b, output int n);
        logic [CH-1:0] m;
        m     = '0;
        m[ch] = 1'b1;
        n     = cyc;
        poke(m, '0, on, off, b);
    endtask

    initial begin
        int n, n2;
        reset   = 1'b0;
        start   = '0;
        stop    = '0;
        on_len  = '0;
        off_len = '0;
        burst   = '0;

        // Reset values on every channel.
        scen = 0;
        for (int ch = 0; ch < int'(CH); ch++) push_idle(ch, 1, 3);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Burst of two 3/2 cycles on ch0.
        scen = 1;
        launch(0, 3, 2, 2, n);
        push_run(0, n, 3, 2, 2, 1'b1);
        repeat (14) @(negedge clk);

        // Continuous 6/4 on ch1, then abort.
        scen = 2;
        launch(1, 6, 4, 0, n);
        push_cont(1, n, 6, 4, 50);
        repeat (49) @(negedge clk);
        push_idle(1, cyc + 1, 2);
        poke(4'b0010, 4'b0010, 6, 4, 0);
        repeat (3) @(negedge clk);

        // Zero lengths behave as 1, then a full-scale ON phase.
        scen = 3;
        launch(0, 0, 0, 1, n);
        push_run(0, n, 0, 0, 1, 1'b1);
        repeat (4) @(negedge clk);
        launch(2, 255, 1, 1, n);
        push_run(2, n, 255, 1, 1, 1'b1);
        repeat (260) @(negedge clk);

        // Independent channels, ignored restart, start+stop together.
        scen = 4;
        launch(0, 4, 3, 2, n);
        push_run(0, n, 4, 3, 2, 1'b1);
        launch(2, 2, 5, 1, n);
        push_run(2, n, 2, 5, 1, 1'b1);
        poke(4'b0001, 4'b0000, 9, 9, 3);
        push_idle(3, cyc + 1, 3);
        poke(4'b1000, 4'b1000, 5, 5, 1);
        repeat (16) @(negedge clk);

        // Restart accepted in the done cycle.
        launch(1, 1, 1, 1, n);
        push_run(1, n, 1, 1, 1, 1'b0);
        repeat (2) @(negedge clk);
        launch(1, 1, 1, 1, n2);
        push_run(1, n2, 1, 1, 1, 1'b1);
        repeat (6) @(negedge clk);

        // Async reset mid-ON, then stays idle after release.
        scen = 5;
        launch(0, 10, 10, 5, n);
        repeat (3) @(negedge clk);
        #2;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].ch == 0 && q[i].cyc > cyc) q.delete(i);
        for (int ch = 0; ch < int'(CH); ch++) push(-1, ch, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        -> async_ev;
        @(negedge clk);
        push_idle(0, cyc + 1, 3);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_idle(0, cyc + 1, 5);
        repeat (6) @(negedge clk);

        for (int k = 0; k < 2000 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain pending got %0d entries want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
